// File: rtl/watchdog_timer_pkg.sv
// Shared definitions for the minisys watchdog: register map, bit positions, default kick key.
package watchdog_timer_pkg;

  typedef enum logic [2:0] {
    RegCtrl   = 3'd0,
    RegLoad   = 3'd1,
    RegWindow = 3'd2,
    RegKick   = 3'd3,
    RegCount  = 3'd4,
    RegStatus = 3'd5
  } wdt_reg_e;

  localparam int unsigned CtrlEn     = 0;
  localparam int unsigned CtrlWinEn  = 1;
  localparam int unsigned CtrlWarnIe = 2;

  localparam int unsigned StWarn     = 0;
  localparam int unsigned StCauseTo  = 1;
  localparam int unsigned StCauseWin = 2;
  localparam int unsigned StCauseKey = 3;

  localparam logic [15:0] KickKeyDefault = 16'hA5C3;

endpackage

// File: rtl/watchdog_timer_if.sv
// Minisys IO bus slice seen by the watchdog: select, strobes, address and data.
interface watchdog_timer_if;
  logic        cs;
  logic [2:0]  addr;
  logic        write_enable;
  logic        read_enable;
  logic [15:0] wdata;
  logic [15:0] rdata;

  modport master (output cs, addr, write_enable, read_enable, wdata, input rdata);
  modport slave  (input cs, addr, write_enable, read_enable, wdata, output rdata);
endinterface

// File: rtl/watchdog_timer_prescaler.sv
// Free-running tick prescaler: one tick per 2**PRE_WIDTH enabled clocks, synchronous clear.
module watchdog_timer_prescaler #(
  parameter int unsigned PRE_WIDTH = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // A zero-width prescaler degenerates to a constant-zero counter, so every enabled clock ticks.
  localparam int unsigned CntW = (PRE_WIDTH == 0) ? 1 : PRE_WIDTH;
  localparam logic [CntW-1:0] CntMax = (PRE_WIDTH == 0) ? {CntW{1'b0}} : {CntW{1'b1}};

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    end
  end

  assign tick = en & (cnt_q == CntMax);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/watchdog_timer.sv
// Bus-programmable two-stage watchdog: first timeout warns, second consecutive timeout
// pulses the CPU reset. Keyed and optionally windowed kicks; sticky cause status.
module watchdog_timer
  import watchdog_timer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned PRE_WIDTH = 4,
  parameter int unsigned PULSE_LEN = 4,
  parameter logic [15:0] KICK_KEY  = KickKeyDefault,
  parameter bit          EN_RESET  = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  watchdog_timer_if.slave  bus,
  output logic             warn_irq,
  output logic             wdt_reset
);

  localparam logic [3:0] PulseLen = 4'(PULSE_LEN);

  logic [2:0]           ctrl_q, ctrl_d;
  logic [CNT_WIDTH-1:0] load_q, load_d, window_q, window_d, count_q, count_d;
  logic [3:0]           status_q, status_d;
  logic [3:0]           pulse_cnt_q, pulse_cnt_d;

  logic wr, rd, wr_ctrl, wr_status, kick_wr;
  logic key_ok, in_window, valid_kick, key_bad, win_bad;
  logic pulse_active, pulse_done, en_rise, tick, expiry, fire, reload;

  assign wr           = bus.cs & bus.write_enable;
  assign rd           = bus.cs & bus.read_enable;
  assign wr_ctrl      = wr & (bus.addr == RegCtrl);
  assign wr_status    = wr & (bus.addr == RegStatus);
  assign pulse_active = (pulse_cnt_q != '0);
  assign pulse_done   = (pulse_cnt_q == 4'd1);

  // Kicks are ignored entirely while the reset pulse is in flight.
  assign kick_wr    = wr & (bus.addr == RegKick) & ~pulse_active;
  assign key_ok     = (bus.wdata == KICK_KEY);
  assign in_window  = ~ctrl_q[CtrlWinEn] | (count_q <= window_q);
  assign valid_kick = kick_wr & key_ok & in_window;
  assign key_bad    = kick_wr & ~key_ok;
  assign win_bad    = kick_wr & key_ok & ~in_window;

  assign en_rise = wr_ctrl & bus.wdata[CtrlEn] & ~ctrl_q[CtrlEn];
  assign expiry  = tick & (count_q == '0) & ~valid_kick;
  assign fire    = ~pulse_active & (key_bad | win_bad | (expiry & status_q[StWarn]));
  assign reload  = valid_kick | en_rise | expiry | pulse_done;

  watchdog_timer_prescaler #(
    .PRE_WIDTH (PRE_WIDTH)
  ) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (ctrl_q[CtrlEn] & ~pulse_active),
    .clr     (reload),
    .tick    (tick)
  );

  always_comb begin
    ctrl_d      = wr_ctrl ? bus.wdata[2:0] : ctrl_q;
    load_d      = (wr & (bus.addr == RegLoad)) ? bus.wdata[CNT_WIDTH-1:0] : load_q;
    window_d    = (wr & (bus.addr == RegWindow)) ? bus.wdata[CNT_WIDTH-1:0] : window_q;

    count_d = count_q;
    if (pulse_active) begin
      if (pulse_done) count_d = load_q;
    end else if (reload) begin
      count_d = load_q;
    end else if (tick) begin
      count_d = count_q - CNT_WIDTH'(1);
    end

    // Clears first, then sets, so a new cause beats a same-clock W1C.
    status_d = status_q;
    if (wr_status) status_d = status_q & ~bus.wdata[3:0];
    if (valid_kick) status_d[StWarn] = 1'b0;
    if (expiry) begin
      if (status_q[StWarn]) begin
        status_d[StWarn]    = 1'b0;
        status_d[StCauseTo] = 1'b1;
      end else begin
        status_d[StWarn] = 1'b1;
      end
    end
    if (win_bad) status_d[StCauseWin] = 1'b1;
    if (key_bad) status_d[StCauseKey] = 1'b1;

    if (fire) begin
      pulse_cnt_d = PulseLen;
    end else if (pulse_active) begin
      pulse_cnt_d = pulse_cnt_q - 4'd1;
    end else begin
      pulse_cnt_d = '0;
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (rd) begin
      case (bus.addr)
        RegCtrl:   bus.rdata = 16'(ctrl_q);
        RegLoad:   bus.rdata = 16'(load_q);
        RegWindow: bus.rdata = 16'(window_q);
        RegCount:  bus.rdata = 16'(count_q);
        RegStatus: bus.rdata = 16'(status_q);
        default:   bus.rdata = '0;
      endcase
    end
  end

  assign warn_irq  = status_q[StWarn] & ctrl_q[CtrlWarnIe];
  assign wdt_reset = pulse_active;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q      <= {2'b00, EN_RESET};
      load_q      <= '1;
      window_q    <= '1;
      count_q     <= '1;
      status_q    <= '0;
      pulse_cnt_q <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      load_q      <= load_d;
      window_q    <= window_d;
      count_q     <= count_d;
      status_q    <= status_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

endmodule

// File: tb/tb_watchdog_timer.sv
// Directed self-checking bench for watchdog_timer (PRE_WIDTH=0 main DUT, PRE_WIDTH=4 side DUT).
module tb_watchdog_timer;
  import watchdog_timer_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  logic warn_irq, wdt_reset, warn_irq4, wdt_reset4;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [15:0] rd;

  watchdog_timer_if bus ();
  watchdog_timer_if bus4 ();

  watchdog_timer #(
    .CNT_WIDTH (16), .PRE_WIDTH (0), .PULSE_LEN (4), .KICK_KEY (16'hA5C3), .EN_RESET (1'b1)
  ) dut (
    .clock (clock), .reset_n (reset_n), .bus (bus), .warn_irq (warn_irq), .wdt_reset (wdt_reset)
  );

  watchdog_timer #(
    .CNT_WIDTH (16), .PRE_WIDTH (4), .PULSE_LEN (4), .KICK_KEY (16'hA5C3), .EN_RESET (1'b1)
  ) dut4 (
    .clock (clock), .reset_n (reset_n), .bus (bus4), .warn_irq (warn_irq4),
    .wdt_reset (wdt_reset4)
  );

  always #5 clock = ~clock;

  task automatic bus_idle();
    bus.cs = 1'b0;  bus.write_enable = 1'b0;  bus.read_enable = 1'b0;
    bus.addr = '0;  bus.wdata = '0;
    bus4.cs = 1'b0; bus4.write_enable = 1'b0; bus4.read_enable = 1'b0;
    bus4.addr = '0; bus4.wdata = '0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Write lands on the next rising edge; returns 1ns after it.
  task automatic bus_write(input bit sel, input logic [2:0] a, input logic [15:0] d);
    if (sel) begin
      bus4.cs = 1'b1; bus4.write_enable = 1'b1; bus4.addr = a; bus4.wdata = d;
    end else begin
      bus.cs = 1'b1;  bus.write_enable = 1'b1;  bus.addr = a;  bus.wdata = d;
    end
    step(1);
    bus_idle();
  endtask

  task automatic bus_read(input bit sel, input logic [2:0] a, output logic [15:0] d);
    if (sel) begin
      bus4.cs = 1'b1; bus4.read_enable = 1'b1; bus4.addr = a;
    end else begin
      bus.cs = 1'b1;  bus.read_enable = 1'b1;  bus.addr = a;
    end
    #1;
    d = sel ? bus4.rdata : bus.rdata;
    bus_idle();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus_idle();
    step(3);
    n_checks++; if (wdt_reset !== 1'b0) begin n_fail++; $display("FAIL rst_wdt: got %b want 0", wdt_reset); end
    n_checks++; if (warn_irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", warn_irq); end
    n_checks++; if (bus.rdata !== 16'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0000", bus.rdata); end
    bus_read(0, RegCount, rd);
    n_checks++; if (rd !== 16'hFFFF) begin n_fail++; $display("FAIL rst_count: got %h want ffff", rd); end
    bus_read(0, RegCtrl, rd);
    n_checks++; if (rd !== 16'h0001) begin n_fail++; $display("FAIL rst_ctrl: got %h want 0001", rd); end
    bus_read(0, RegWindow, rd);
    n_checks++; if (rd !== 16'hFFFF) begin n_fail++; $display("FAIL rst_window: got %h want ffff", rd); end
    bus_read(0, RegStatus, rd);
    n_checks++; if (rd !== 16'h0) begin n_fail++; $display("FAIL rst_status: got %h want 0000", rd); end
    reset_n = 1'b1;
    // Bad key starts a pulse; async reset must kill it immediately.
    bus_write(0, RegKick, 16'h1234);
    n_checks++; if (wdt_reset !== 1'b1) begin n_fail++; $display("FAIL rst_pulse_up: got %b want 1", wdt_reset); end
    step(1);
    reset_n = 1'b0;
    #1;
    n_checks++; if (wdt_reset !== 1'b0) begin n_fail++; $display("FAIL rst_midpulse: got %b want 0", wdt_reset); end
    bus_read(0, RegCount, rd);
    n_checks++; if (rd !== 16'hFFFF) begin n_fail++; $display("FAIL rst_midpulse_count: got %h want ffff", rd); end
    bus_read(0, RegCtrl, rd);
    n_checks++; if (rd !== 16'h0001) begin n_fail++; $display("FAIL rst_midpulse_ctrl: got %h want 0001", rd); end
    step(1);
    reset_n = 1'b1;
  endtask

  task automatic test_two_stage();
    int hi;
    bus_write(0, RegCtrl, 16'h0);
    bus_write(0, RegLoad, 16'd10);
    bus_write(0, RegCtrl, 16'h5);
    step(10);
    n_checks++; if (warn_irq !== 1'b0) begin n_fail++; $display("FAIL ts_irq_early: got %b want 0", warn_irq); end
    bus_read(0, RegCount, rd);
    n_checks++; if (rd !== 16'd0) begin n_fail++; $display("FAIL ts_count0: got %0d want 0", rd); end
    step(1);
    n_checks++; if (warn_irq !== 1'b1) begin n_fail++; $display("FAIL ts_irq: got %b want 1", warn_irq); end
    bus_read(0, RegStatus, rd);
    n_checks++; if (rd !== 16'h1) begin n_fail++; $display("FAIL ts_status_warn: got %h want 0001", rd); end
    bus_read(0, RegCount, rd);
    n_checks++; if (rd !== 16'd10) begin n_fail++; $display("FAIL ts_reload: got %0d want 10", rd); end
    step(10);
    n_checks++; if (wdt_reset !== 1'b0) begin n_fail++; $display("FAIL ts_wdt_early: got %b want 0", wdt_reset); end
    step(1);
    n_checks++; if (wdt_reset !== 1'b1) begin n_fail++; $display("FAIL ts_wdt: got %b want 1", wdt_reset); end
    n_checks++; if (warn_irq !== 1'b0) begin n_fail++; $display("FAIL ts_irq_clr: got %b want 0", warn_irq); end
    bus_read(0, RegStatus, rd);
    n_checks++; if (rd !== 16'h2) begin n_fail++; $display("FAIL ts_status_to: got %h want 0002", rd); end
    hi = 1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (wdt_reset === 1'b1) hi++;
    end
    n_checks++; if (hi != 4) begin n_fail++; $display("FAIL ts_pulse_len: got %0d want 4", hi); end
    bus_read(0, RegCount, rd);
    n_checks++; if (rd !== 16'd6) begin n_fail++; $display("FAIL ts_post_pulse_count: got %0d want 6", rd); end
    bus_write(0, RegStatus, 16'hF);
    bus_read(0, RegStatus, rd);
    n_checks++; if (rd !== 16'h0) begin n_fail++; $display("FAIL ts_w1c: got %h want 0000", rd); end
    bus_write(0, RegCtrl, 16'h0);
  endtask

  task automatic test_kick();
    bit seen;
    seen = 1'b0;
    bus_write(0, RegLoad, 16'd10);
    bus_write(0, RegCtrl, 16'h1);
    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < 7; i++) begin
        step(1);
        if (wdt_reset !== 1'b0) seen = 1'b1;
      end
      bus_write(0, RegKick, 16'hA5C3);
      if (wdt_reset !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL kick_no_pulse: got %b want 0", seen); end
    bus_read(0, RegStatus, rd);
    n_checks++; if (rd !== 16'h0) begin n_fail++; $display("FAIL kick_no_warn: got %h want 0000", rd); end
    bus_read(0, RegKick, rd);
    n_checks++; if (rd !== 16'h0) begin n_fail++; $display("FAIL kick_read0: got %h want 0000", rd); end
    bus_write(0, RegKick, 16'h1234);
    n_checks++; if (wdt_reset !== 1'b1) begin n_fail++; $display("FAIL badkey_pulse: got %b want 1", wdt_reset); end
    bus_read(0, RegStatus, rd);
    n_checks++; if (rd !== 16'h8) begin n_fail++; $display("FAIL badkey_status: got %h want 0008", rd); end
    step(4);
    n_checks++; if (wdt_reset !== 1'b0) begin n_fail++; $display("FAIL badkey_pulse_end: got %b want 0", wdt_reset); end
    bus_write(0, RegStatus, 16'hF);
    bus_write(0, RegCtrl, 16'h0);
  endtask

  task automatic test_window();
    bus_write(0, RegLoad, 16'd100);
    bus_write(0, RegWindow, 16'd20);
    bus_write(0, RegCtrl, 16'h3);
    step(50);
    bus_read(0, RegCount, rd);
    n_checks++; if (rd !== 16'd50) begin n_fail++; $display("FAIL win_count50: got %0d want 50", rd); end
    bus_write(0, RegKick, 16'hA5C3);
    n_checks++; if (wdt_reset !== 1'b1) begin n_fail++; $display("FAIL win_early_pulse: got %b want 1", wdt_reset); end
    bus_read(0, RegStatus, rd);
    n_checks++; if (rd !== 16'h4) begin n_fail++; $display("FAIL win_cause: got %h want 0004", rd); end
    step(4);
    n_checks++; if (wdt_reset !== 1'b0) begin n_fail++; $display("FAIL win_pulse_end: got %b want 0", wdt_reset); end
    bus_read(0, RegCount, rd);
    n_checks++; if (rd !== 16'd100) begin n_fail++; $display("FAIL win_pulse_reload: got %0d want 100", rd); end
    step(85);
    bus_read(0, RegCount, rd);
    n_checks++; if (rd !== 16'd15) begin n_fail++; $display("FAIL win_count15: got %0d want 15", rd); end
    bus_write(0, RegKick, 16'hA5C3);
    n_checks++; if (wdt_reset !== 1'b0) begin n_fail++; $display("FAIL win_ok_nopulse: got %b want 0", wdt_reset); end
    bus_read(0, RegCount, rd);
    n_checks++; if (rd !== 16'd100) begin n_fail++; $display("FAIL win_ok_reload: got %0d want 100", rd); end
    bus_read(0, RegStatus, rd);
    n_checks++; if (rd !== 16'h4) begin n_fail++; $display("FAIL win_sticky: got %h want 0004", rd); end
    bus_write(0, RegStatus, 16'hF);
    bus_write(0, RegCtrl, 16'h0);
  endtask

  task automatic test_collision();
    bus_write(0, RegLoad, 16'd5);
    bus_write(0, RegCtrl, 16'h1);
    step(5);
    bus_read(0, RegCount, rd);
    n_checks++; if (rd !== 16'd0) begin n_fail++; $display("FAIL col_count0: got %0d want 0", rd); end
    bus_write(0, RegKick, 16'hA5C3);
    bus_read(0, RegCount, rd);
    n_checks++; if (rd !== 16'd5) begin n_fail++; $display("FAIL col_count: got %0d want 5", rd); end
    bus_read(0, RegStatus, rd);
    n_checks++; if (rd !== 16'h0) begin n_fail++; $display("FAIL col_status: got %h want 0000", rd); end
    n_checks++; if (wdt_reset !== 1'b0) begin n_fail++; $display("FAIL col_wdt: got %b want 0", wdt_reset); end
    step(6);
    bus_read(0, RegStatus, rd);
    n_checks++; if (rd !== 16'h1) begin n_fail++; $display("FAIL col_next_warn: got %h want 0001", rd); end
    bus_write(0, RegStatus, 16'h1);
    step(4);
    // W1C lands on the same edge as an expiry that sets WARN.
    bus_write(0, RegStatus, 16'hF);
    bus_read(0, RegStatus, rd);
    n_checks++; if (rd !== 16'h1) begin n_fail++; $display("FAIL set_beats_w1c: got %h want 0001", rd); end
    bus_write(0, RegCtrl, 16'h0);
    bus_write(0, RegKick, 16'hA5C3);
    bus_read(0, RegStatus, rd);
    n_checks++; if (rd !== 16'h0) begin n_fail++; $display("FAIL kick_clr_warn: got %h want 0000", rd); end
    bus_read(0, RegCount, rd);
    n_checks++; if (rd !== 16'd5) begin n_fail++; $display("FAIL kick_en0_reload: got %0d want 5", rd); end
  endtask

  task automatic test_misc();
    step(10);
    bus_read(0, RegCount, rd);
    n_checks++; if (rd !== 16'd5) begin n_fail++; $display("FAIL freeze: got %0d want 5", rd); end
    bus_write(0, RegLoad, 16'd0);
    bus_write(0, RegCtrl, 16'h1);
    step(1);
    bus_read(0, RegStatus, rd);
    n_checks++; if (rd !== 16'h1) begin n_fail++; $display("FAIL load0_warn: got %h want 0001", rd); end
    step(1);
    n_checks++; if (wdt_reset !== 1'b1) begin n_fail++; $display("FAIL load0_pulse: got %b want 1", wdt_reset); end
    bus_read(0, RegStatus, rd);
    n_checks++; if (rd !== 16'h2) begin n_fail++; $display("FAIL load0_cause: got %h want 0002", rd); end
    step(4);
    bus_write(0, RegCtrl, 16'h0);
    bus_write(0, RegStatus, 16'hF);
  endtask

  task automatic test_prescaler();
    bus_write(1, RegCtrl, 16'h0);
    bus_write(1, RegLoad, 16'd100);
    bus_write(1, RegCtrl, 16'h1);
    step(15);
    bus_read(1, RegCount, rd);
    n_checks++; if (rd !== 16'd100) begin n_fail++; $display("FAIL pre_hold15: got %0d want 100", rd); end
    step(1);
    bus_read(1, RegCount, rd);
    n_checks++; if (rd !== 16'd99) begin n_fail++; $display("FAIL pre_tick16: got %0d want 99", rd); end
    step(16);
    bus_read(1, RegCount, rd);
    n_checks++; if (rd !== 16'd98) begin n_fail++; $display("FAIL pre_tick32: got %0d want 98", rd); end
    n_checks++; if ({warn_irq4, wdt_reset4} !== 2'b00) begin
      n_fail++; $display("FAIL pre_outputs: got %b want 00", {warn_irq4, wdt_reset4});
    end
  endtask

  initial begin
    test_reset();
    test_two_stage();
    test_kick();
    test_window();
    test_collision();
    test_misc();
    test_prescaler();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
